// File: rtl/trisc_pkg.sv
// rtl/trisc_pkg.sv - shared opcodes, state encoding and ALU codes for the TRISC sequencer
// Contents: opcode constants, sequencer state enum, alu_op codes, wait counter width.

package trisc_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_INCA = 4'd1;
  localparam logic [3:0] OP_CLRA = 4'd2;
  localparam logic [3:0] OP_LDA  = 4'd3;
  localparam logic [3:0] OP_STA  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_JZ   = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  // Wide enough for the largest legal timeout (255).
  localparam int TMR_W = 8;

  typedef enum logic [3:0] {
    S_RST,
    S_FA,
    S_FR,
    S_IRL,
    S_DEC,
    S_INC,
    S_CLR,
    S_OA,
    S_OR,
    S_OL,
    S_ALU,
    S_SW,
    S_JL,
    S_HALT
  } state_t;

endpackage

// File: rtl/trisc_wait_timer.sv
// rtl/trisc_wait_timer.sv - memory handshake wait counter with timeout flag
// Ports: clk, CLR_n (async active-low reset), clear (sync zero), enable (count one wait cycle),
//        expired (count has reached MEM_TMO).

module trisc_wait_timer
  import trisc_pkg::*;
#(
  parameter int MEM_TMO = 15
) (
  input  logic clk,
  input  logic CLR_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] TMO = TMR_W'(MEM_TMO);

  logic [TMR_W-1:0] cnt;

  // Saturates at the timeout value so a stuck enable cannot wrap around.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign expired = (cnt == TMO);

endmodule

// File: rtl/trisc_seq_ctrl.sv
// rtl/trisc_seq_ctrl.sv - TRISC instruction sequencer (fetch/decode/execute control FSM)
// Inputs:  clk, CLR_n (async active-low reset), opcode, acc_zero, mem_rdy, run.
// Outputs: pc_clr/pc_inc/pc_ld, addr_sel, mem_rd/mem_wr, ir_ld,
//          acc_clr/acc_inc/acc_ld/acc_sel, alu_op, instr_done, halted, illegal, bus_err.

module trisc_seq_ctrl
  import trisc_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MEM_TMO = 15
) (
  input  logic            clk,
  input  logic            CLR_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            acc_zero,
  input  logic            mem_rdy,
  input  logic            run,
  output logic            pc_clr,
  output logic            pc_inc,
  output logic            pc_ld,
  output logic            addr_sel,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            ir_ld,
  output logic            acc_clr,
  output logic            acc_inc,
  output logic            acc_ld,
  output logic            acc_sel,
  output logic [1:0]      alu_op,
  output logic            instr_done,
  output logic            halted,
  output logic            illegal,
  output logic            bus_err
);

  state_t     state, state_nx;
  logic [3:0] op_q;
  logic       illegal_q, illegal_nx;
  logic       bus_err_q, bus_err_nx;
  logic       in_wait, tmo_exp, timeout;
  logic       op_hi_nz;
  logic [3:0] op_lo;

  // Any set bit above bit 3 makes the opcode illegal regardless of the low nibble.
  assign op_hi_nz = |(opcode >> 4);
  assign op_lo    = opcode[3:0];

  // The timer is held at zero outside the handshake states, so it is zero on entry.
  assign in_wait = (state == S_FR) || (state == S_OR) || (state == S_SW);
  assign timeout = in_wait && !mem_rdy && tmo_exp;

  trisc_wait_timer #(.MEM_TMO(MEM_TMO)) u_wait_timer (
    .clk     (clk),
    .CLR_n   (CLR_n),
    .clear   (!in_wait),
    .enable  (in_wait && !mem_rdy),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state     <= S_RST;
      op_q      <= OP_NOP;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      illegal_q <= illegal_nx;
      bus_err_q <= bus_err_nx;
      // Operand phases run after the IR may have moved on, so keep our own copy.
      if (state == S_DEC) op_q <= op_lo;
    end
  end

  always_comb begin
    state_nx   = state;
    illegal_nx = illegal_q;
    bus_err_nx = bus_err_q;
    case (state)
      S_RST: state_nx = S_FA;
      S_FA:  state_nx = S_FR;
      S_FR: begin
        if (timeout) begin
          state_nx   = S_HALT;
          bus_err_nx = 1'b1;
        end else if (mem_rdy) begin
          state_nx = S_IRL;
        end
      end
      S_IRL: state_nx = S_DEC;
      S_DEC: begin
        if (op_hi_nz) begin
          state_nx   = S_HALT;
          illegal_nx = 1'b1;
        end else begin
          case (op_lo)
            OP_NOP:                        state_nx = S_FA;
            OP_INCA:                       state_nx = S_INC;
            OP_CLRA:                       state_nx = S_CLR;
            OP_LDA, OP_ADD, OP_SUB, OP_STA: state_nx = S_OA;
            OP_JMP:                        state_nx = S_JL;
            OP_JZ:                         state_nx = acc_zero ? S_JL : S_FA;
            OP_HLT:                        state_nx = S_HALT;
            default: begin
              state_nx   = S_HALT;
              illegal_nx = 1'b1;
            end
          endcase
        end
      end
      S_INC, S_CLR, S_JL, S_OL, S_ALU: state_nx = S_FA;
      S_OA: state_nx = (op_q == OP_STA) ? S_SW : S_OR;
      S_OR: begin
        if (timeout) begin
          state_nx   = S_HALT;
          bus_err_nx = 1'b1;
        end else if (mem_rdy) begin
          state_nx = (op_q == OP_LDA) ? S_OL : S_ALU;
        end
      end
      S_SW: begin
        if (timeout) begin
          state_nx   = S_HALT;
          bus_err_nx = 1'b1;
        end else if (mem_rdy) begin
          state_nx = S_FA;
        end
      end
      S_HALT: begin
        if (run) begin
          state_nx   = S_FA;
          illegal_nx = 1'b0;
          bus_err_nx = 1'b0;
        end
      end
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    pc_clr     = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    addr_sel   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_ld      = 1'b0;
    acc_clr    = 1'b0;
    acc_inc    = 1'b0;
    acc_ld     = 1'b0;
    acc_sel    = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    case (state)
      S_RST: pc_clr = 1'b1;
      S_FR:  mem_rd = 1'b1;
      S_IRL: ir_ld  = 1'b1;
      S_DEC: begin
        pc_inc = 1'b1;
        // DEC is the final state for NOP, HLT and an untaken JZ.
        instr_done = !op_hi_nz && ((op_lo == OP_NOP) || (op_lo == OP_HLT) ||
                                   ((op_lo == OP_JZ) && !acc_zero));
      end
      S_INC: begin
        acc_inc    = 1'b1;
        instr_done = 1'b1;
      end
      S_CLR: begin
        acc_clr    = 1'b1;
        instr_done = 1'b1;
      end
      S_JL: begin
        addr_sel   = 1'b1;
        pc_ld      = 1'b1;
        instr_done = 1'b1;
      end
      S_OA: addr_sel = 1'b1;
      S_OR: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
      end
      S_OL: begin
        acc_ld     = 1'b1;
        instr_done = 1'b1;
      end
      S_ALU: begin
        acc_sel    = 1'b1;
        acc_ld     = 1'b1;
        alu_op     = (op_q == OP_SUB) ? ALU_SUB : ALU_ADD;
        instr_done = 1'b1;
      end
      S_SW: begin
        addr_sel   = 1'b1;
        mem_wr     = 1'b1;
        // Only a completed write ends the instruction; a timeout leaves via mem_rdy=0.
        instr_done = mem_rdy;
      end
      default: ;
    endcase
  end

  assign halted  = (state == S_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_trisc_seq_ctrl.sv
// tb/tb_trisc_seq_ctrl.sv - directed self-checking bench for trisc_seq_ctrl

module tb_trisc_seq_ctrl;
  import trisc_pkg::*;

  // Output vector layout:
  // [16]pc_clr [15]pc_inc [14]pc_ld [13]addr_sel [12]mem_rd [11]mem_wr [10]ir_ld
  // [9]acc_clr [8]acc_inc [7]acc_ld [6]acc_sel [5:4]alu_op [3]instr_done
  // [2]halted [1]illegal [0]bus_err
  localparam logic [16:0] O_RST      = 17'h10000;
  localparam logic [16:0] O_FA       = 17'h00000;
  localparam logic [16:0] O_FR       = 17'h01000;
  localparam logic [16:0] O_IRL      = 17'h00400;
  localparam logic [16:0] O_DEC      = 17'h08000;
  localparam logic [16:0] O_DEC_D    = 17'h08008;
  localparam logic [16:0] O_INC      = 17'h00108;
  localparam logic [16:0] O_CLR      = 17'h00208;
  localparam logic [16:0] O_JL       = 17'h06008;
  localparam logic [16:0] O_OA       = 17'h02000;
  localparam logic [16:0] O_OR       = 17'h03000;
  localparam logic [16:0] O_OL       = 17'h00088;
  localparam logic [16:0] O_ADD      = 17'h000C8;
  localparam logic [16:0] O_SUB      = 17'h000D8;
  localparam logic [16:0] O_SW       = 17'h02800;
  localparam logic [16:0] O_SW_D     = 17'h02808;
  localparam logic [16:0] O_HALT     = 17'h00004;
  localparam logic [16:0] O_HALT_ILL = 17'h00006;
  localparam logic [16:0] O_HALT_BE  = 17'h00005;

  logic       clk = 1'b0;
  logic       CLR_n;
  logic [3:0] opcode;
  logic       acc_zero, mem_rdy, run;
  logic       pc_clr, pc_inc, pc_ld, addr_sel, mem_rd, mem_wr, ir_ld;
  logic       acc_clr, acc_inc, acc_ld, acc_sel;
  logic [1:0] alu_op;
  logic       instr_done, halted, illegal, bus_err;
  logic [16:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trisc_seq_ctrl #(.OP_W(4), .MEM_TMO(15)) dut (
    .clk        (clk),
    .CLR_n      (CLR_n),
    .opcode     (opcode),
    .acc_zero   (acc_zero),
    .mem_rdy    (mem_rdy),
    .run        (run),
    .pc_clr     (pc_clr),
    .pc_inc     (pc_inc),
    .pc_ld      (pc_ld),
    .addr_sel   (addr_sel),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_ld      (ir_ld),
    .acc_clr    (acc_clr),
    .acc_inc    (acc_inc),
    .acc_ld     (acc_ld),
    .acc_sel    (acc_sel),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  assign obs = {pc_clr, pc_inc, pc_ld, addr_sel, mem_rd, mem_wr, ir_ld,
                acc_clr, acc_inc, acc_ld, acc_sel, alu_op, instr_done,
                halted, illegal, bus_err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and check the outputs of the state just entered.
  task automatic cyc(input string tag, input logic [16:0] exp);
    @(posedge clk);
    #2;
    chk(tag, 32'(obs), 32'(exp));
  endtask

  // FA has already been checked; step through FR and IRL with mem_rdy high.
  task automatic fetch(input string tag);
    cyc({tag, "_fr"}, O_FR);
    cyc({tag, "_irl"}, O_IRL);
  endtask

  logic [3:0] ill_ops [3];

  initial begin
    CLR_n    = 1'b0;
    opcode   = OP_NOP;
    acc_zero = 1'b0;
    mem_rdy  = 1'b1;
    run      = 1'b0;
    ill_ops[0] = 4'hA;
    ill_ops[1] = 4'hC;
    ill_ops[2] = 4'hF;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_out", 32'(obs), 32'(O_RST));
    CLR_n = 1'b1;
    cyc("rst_exit", O_FA);

    // NOP, INCA, HLT: instr_done in cycles 4, 9, 13; run is ignored outside HALT.
    opcode = OP_NOP; run = 1'b1;
    fetch("nop"); cyc("nop_dec", O_DEC_D); cyc("nop_end", O_FA);
    opcode = OP_INCA; run = 1'b0;
    fetch("inca"); cyc("inca_dec", O_DEC); cyc("inca_inc", O_INC); cyc("inca_end", O_FA);
    opcode = OP_HLT;
    fetch("hlt"); cyc("hlt_dec", O_DEC_D); cyc("hlt_halt", O_HALT);
    opcode = OP_INCA;
    cyc("halt_hold1", O_HALT); cyc("halt_hold2", O_HALT);
    run = 1'b1; cyc("hlt_run", O_FA); run = 1'b0;

    opcode = OP_CLRA;
    fetch("clra"); cyc("clra_dec", O_DEC); cyc("clra_clr", O_CLR); cyc("clra_end", O_FA);

    // LDA with three wait cycles in OR: OR held 4 cycles, 10 cycles total.
    opcode = OP_LDA;
    fetch("lda"); cyc("lda_dec", O_DEC); cyc("lda_oa", O_OA);
    mem_rdy = 1'b0;
    cyc("lda_or1", O_OR); cyc("lda_or2", O_OR); cyc("lda_or3", O_OR); cyc("lda_or4", O_OR);
    mem_rdy = 1'b1;
    cyc("lda_ol", O_OL); cyc("lda_end", O_FA);

    opcode = OP_ADD;
    fetch("add"); cyc("add_dec", O_DEC); cyc("add_oa", O_OA); cyc("add_or", O_OR);
    cyc("add_alu", O_ADD); cyc("add_end", O_FA);
    opcode = OP_SUB;
    fetch("sub"); cyc("sub_dec", O_DEC); cyc("sub_oa", O_OA); cyc("sub_or", O_OR);
    cyc("sub_alu", O_SUB); cyc("sub_end", O_FA);

    opcode = OP_STA;
    fetch("sta"); cyc("sta_dec", O_DEC); cyc("sta_oa", O_OA); cyc("sta_sw", O_SW_D);
    cyc("sta_end", O_FA);

    opcode = OP_JZ; acc_zero = 1'b1;
    fetch("jzt"); cyc("jzt_dec", O_DEC); cyc("jzt_jl", O_JL); cyc("jzt_end", O_FA);
    acc_zero = 1'b0;
    fetch("jzn"); cyc("jzn_dec", O_DEC_D); cyc("jzn_end", O_FA);
    opcode = OP_JMP;
    fetch("jmp"); cyc("jmp_dec", O_DEC); cyc("jmp_jl", O_JL); cyc("jmp_end", O_FA);

    // STA with mem_rdy stuck low: 15 wait cycles then bus error.
    opcode = OP_STA;
    fetch("tmo"); cyc("tmo_dec", O_DEC); cyc("tmo_oa", O_OA);
    mem_rdy = 1'b0;
    for (int i = 0; i < 16; i++) cyc($sformatf("tmo_sw%0d", i), O_SW);
    cyc("tmo_halt", O_HALT_BE);
    mem_rdy = 1'b1;
    cyc("tmo_hold", O_HALT_BE);
    run = 1'b1; cyc("tmo_run", O_FA); run = 1'b0;

    foreach (ill_ops[k]) begin
      opcode = ill_ops[k];
      fetch($sformatf("ill%0d", k));
      cyc($sformatf("ill%0d_dec", k), O_DEC);
      cyc($sformatf("ill%0d_halt", k), O_HALT_ILL);
      run = 1'b1; cyc($sformatf("ill%0d_run", k), O_FA); run = 1'b0;
    end

    // Reset out of HALT with illegal set clears the flag.
    opcode = 4'hC;
    fetch("illr"); cyc("illr_dec", O_DEC); cyc("illr_halt", O_HALT_ILL);
    #1 CLR_n = 1'b0;
    #1 chk("illr_async", 32'(obs), 32'(O_RST));
    CLR_n = 1'b1;
    cyc("illr_exit", O_FA);

    // Asynchronous reset in the middle of an OR wait.
    opcode = OP_LDA;
    fetch("rstor"); cyc("rstor_dec", O_DEC); cyc("rstor_oa", O_OA);
    mem_rdy = 1'b0;
    cyc("rstor_or", O_OR);
    #1 CLR_n = 1'b0;
    #1 chk("rstor_async", 32'(obs), 32'(O_RST));
    cyc("rstor_hold", O_RST);
    CLR_n = 1'b1; mem_rdy = 1'b1;
    cyc("rstor_exit", O_FA);
    fetch("rstor2"); cyc("rstor2_dec", O_DEC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
